trace_cmd_sequencer: RTL
========================

Name: trace_cmd_sequencer

Overview:
- Front-end controller for the cache simulator.
- Accepts trace commands (n, address) one at a time and dispatches each to the L1 instruction cache or L1 data cache.
- Waits for each lookup's hit/miss response and converts it into one-cycle increment strobes for the statistics counters.
- Also sequences the global clear (n=8) and print (n=9) operations across both caches and the statistics block.

Parameters:
- AW, 32: trace address width.
- CW, 32: width of the accepted-command counter.
- TIMEOUT, 1024: cycles to wait for any response before abandoning it; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  trace command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_n  in  4  trace opcode.
- cmd_addr  in  AW  trace address.
- d_req_valid  out  1  D-cache request.
- d_req_ready  in  1  D-cache accepts the request.
- d_req_op  out  2  0=READ, 1=WRITE, 2=SNOOP_INV, 3=SNOOP_RD.
- d_req_addr  out  AW  D-cache address.
- d_resp_valid  in  1  D-cache response.
- d_resp_hit  in  1  1=hit, 0=miss.
- i_req_valid  out  1  I-cache fetch request.
- i_req_ready  in  1  I-cache accepts the request.
- i_req_addr  out  AW  I-cache address.
- i_resp_valid  in  1  I-cache response.
- i_resp_hit  in  1  1=hit, 0=miss.
- clr_req  out  1  clear request to both caches.
- i_clr_done  in  1  I-cache clear finished (pulse).
- d_clr_done  in  1  D-cache clear finished (pulse).
- print_req  out  1  print request.
- print_done  in  1  print finished (pulse).
- i_hit, i_miss, d_hit, d_miss  out  1 each  one-cycle strobes to the statistics block.
- stats_clr  out  1  one-cycle pulse that clears the statistics counters.
- bad_cmd  out  1  one-cycle pulse when an illegal opcode is dropped.
- timeout  out  1  one-cycle pulse when the watchdog expires.
- cmd_count  out  CW  number of legal commands accepted.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all req/strobe/pulse outputs 0; cmd_count 0; addr/op registers 0; watchdog 0; clear flags 0. A reset mid-operation abandons the operation and emits no strobes.
- States: IDLE, D_ISSUE, D_WAIT, I_ISSUE, I_WAIT, CLEAR, PRINT.
- cmd_ready = (state==IDLE), decoded from the state register. Accept occurs on cmd_valid & cmd_ready; n and addr are latched at accept.
- Decode at accept:
  - n=0,1 -> D_ISSUE with op READ/WRITE.
  - n=3 -> D_ISSUE with op SNOOP_INV.
  - n=4 -> D_ISSUE with op SNOOP_RD.
  - n=2 -> I_ISSUE.
  - n=8 -> CLEAR.
  - n=9 -> PRINT.
  - Any other n -> stay in IDLE, pulse bad_cmd next cycle, cmd_count unchanged.
- cmd_count increments on each legal accept and saturates at all-ones. It is zeroed in the cycle stats_clr pulses.
- *_ISSUE states: req_valid is high from the cycle after accept. Address and op stay stable until ready is sampled high, then the state moves to *_WAIT.
- *_WAIT states:
  - Only the matching resp_valid is honoured. Responses arriving in any other state, or from the other cache, are ignored.
  - On resp_valid the state returns to IDLE.
  - For n=0,1: in the next cycle pulse d_hit or d_miss according to d_resp_hit.
  - For n=2: pulse i_hit or i_miss.
  - For n=3,4: no statistics strobe (snoops are not counted).
- Minimum latency, with the cache accepting immediately and responding in the first wait cycle:
  - accept at T, req_valid at T+1, WAIT at T+2, resp at T+2, strobe and cmd_ready at T+3.
  - A new command can be accepted at T+3, in the same cycle the strobe pulses.
- CLEAR:
  - clr_req is held high.
  - i_clr_done and d_clr_done are captured in sticky flags, so they may arrive in any order, in the same cycle, or on the cycle CLEAR is entered.
  - When both flags are set, the next cycle: clr_req=0, stats_clr pulse, flags cleared, state IDLE.
- PRINT: print_req is held high until print_done, then the state returns to IDLE the next cycle.
- Watchdog:
  - Counts cycles spent in *_WAIT, CLEAR and PRINT. It resets on every state entry.
  - When TIMEOUT!=0 and the count reaches TIMEOUT: drop all requests, pulse timeout, go to IDLE, emit no statistics strobe or stats_clr.
  - A response arriving in the same cycle as expiry wins: the response is processed normally and timeout is not pulsed.
- At most one statistics strobe is high in any cycle.

Decomposition:
- Shared package cache_sim_pkg:
  - opcode constants CMD_RD_D=0, CMD_WR_D=1, CMD_RD_I=2, CMD_INV=3, CMD_SNP_RD=4, CMD_CLR=8, CMD_PRT=9;
  - enum d_op_t {READ, WRITE, SNOOP_INV, SNOOP_RD};
  - enum seq_state_t.
- One natural sub-module: seq_watchdog, a loadable down-counter with an expire pulse.

Test Plan:
- n=0 addr=0x1000, cache ready immediately, d_resp_hit=1 two cycles after accept -> d_req_op=READ, d_req_addr=0x1000, exactly one d_hit pulse, cmd_count=1, cmd_ready high on the strobe cycle.
- n=2 addr=0x40, i_req_ready low for 3 cycles, then a miss response -> i_req_addr stable through the stall, one i_miss pulse, no d_* strobes.
- n=3 then n=4 with hit responses -> ops SNOOP_INV then SNOOP_RD, no statistics strobes, cmd_count=2.
- n=8 with d_clr_done 2 cycles before i_clr_done -> clr_req held until both are seen, one stats_clr pulse, cmd_count=0 afterwards.
- n=5 -> bad_cmd pulses once, no request issued, cmd_count unchanged; TIMEOUT=8 with n=1 and no response -> timeout pulses after 8 wait cycles, no d_write strobe, back in IDLE.
- rst_n asserted during D_WAIT -> all outputs 0 immediately; a late d_resp_valid after reset produces no strobe.

Source files
------------

// File: rtl/cache_sim_pkg.sv
// cache_sim_pkg: opcodes, request op and sequencer state types shared by the cache simulator front end.
package cache_sim_pkg;
  localparam logic [3:0] CMD_RD_D   = 4'd0;
  localparam logic [3:0] CMD_WR_D   = 4'd1;
  localparam logic [3:0] CMD_RD_I   = 4'd2;
  localparam logic [3:0] CMD_INV    = 4'd3;
  localparam logic [3:0] CMD_SNP_RD = 4'd4;
  localparam logic [3:0] CMD_CLR    = 4'd8;
  localparam logic [3:0] CMD_PRT    = 4'd9;
  typedef enum logic [1:0] {READ, WRITE, SNOOP_INV, SNOOP_RD} d_op_t;
  typedef enum logic [2:0] {IDLE, D_ISSUE, D_WAIT, I_ISSUE, I_WAIT, CLEAR, PRINT} seq_state_t;
  // Illegal opcodes map to IDLE so the caller can use that as the "drop" indication.
  function automatic seq_state_t decode_state(input logic [3:0] n);
    case (n)
      CMD_RD_D, CMD_WR_D, CMD_INV, CMD_SNP_RD: decode_state = D_ISSUE;
      CMD_RD_I: decode_state = I_ISSUE;
      CMD_CLR:  decode_state = CLEAR;
      CMD_PRT:  decode_state = PRINT;
      default:  decode_state = IDLE;
    endcase
  endfunction
  function automatic d_op_t decode_op(input logic [3:0] n);
    decode_op = (n == CMD_WR_D) ? WRITE : (n == CMD_INV) ? SNOOP_INV : (n == CMD_SNP_RD) ? SNOOP_RD : READ;
  endfunction
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: loadable down-counter; o_expire is high in the TIMEOUT-th enabled cycle after a load.
module seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] LOAD = WW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  logic [WW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= LOAD;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == '0);
endmodule

// File: rtl/trace_cmd_sequencer.sv
// trace_cmd_sequencer: dispatches trace commands to the L1 I/D caches, turns lookup responses into
// statistics strobes and sequences the global clear and print operations.
module trace_cmd_sequencer
  import cache_sim_pkg::*;
#(
  parameter int AW      = 32,
  parameter int CW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_n,
  input  logic [AW-1:0] cmd_addr,
  output logic          d_req_valid,
  input  logic          d_req_ready,
  output logic [1:0]    d_req_op,
  output logic [AW-1:0] d_req_addr,
  input  logic          d_resp_valid,
  input  logic          d_resp_hit,
  output logic          i_req_valid,
  input  logic          i_req_ready,
  output logic [AW-1:0] i_req_addr,
  input  logic          i_resp_valid,
  input  logic          i_resp_hit,
  output logic          clr_req,
  input  logic          i_clr_done,
  input  logic          d_clr_done,
  output logic          print_req,
  input  logic          print_done,
  output logic          i_hit,
  output logic          i_miss,
  output logic          d_hit,
  output logic          d_miss,
  output logic          stats_clr,
  output logic          bad_cmd,
  output logic          timeout,
  output logic [CW-1:0] cmd_count,
  output logic          busy
);
  seq_state_t    r_state, w_next;
  d_op_t         r_op;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_count;
  logic          r_iflag, r_dflag;
  logic          r_i_hit, r_i_miss, r_d_hit, r_d_miss, r_stats_clr, r_bad, r_timeout;
  logic          w_accept, w_legal, w_expire, w_d_done, w_i_done, w_clr_done, w_prt_done, w_timeout, w_d_count;
  assign w_accept   = cmd_valid && (r_state == IDLE);
  assign w_legal    = decode_state(cmd_n) != IDLE;
  assign w_d_done   = (r_state == D_WAIT) && d_resp_valid;
  assign w_i_done   = (r_state == I_WAIT) && i_resp_valid;
  assign w_clr_done = (r_state == CLEAR) && r_iflag && r_dflag;
  assign w_prt_done = (r_state == PRINT) && print_done;
  // A completion landing on the expiry cycle takes precedence over the watchdog.
  assign w_timeout  = w_expire && !(w_d_done || w_i_done || w_clr_done || w_prt_done);
  assign w_d_count  = (r_op == READ) || (r_op == WRITE);
  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_next != r_state),
    .i_en     (r_state inside {D_WAIT, I_WAIT, CLEAR, PRINT}),
    .o_expire (w_expire)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? decode_state(cmd_n) : IDLE;
      D_ISSUE: w_next = d_req_ready ? D_WAIT : D_ISSUE;
      D_WAIT:  w_next = (w_d_done || w_timeout) ? IDLE : D_WAIT;
      I_ISSUE: w_next = i_req_ready ? I_WAIT : I_ISSUE;
      I_WAIT:  w_next = (w_i_done || w_timeout) ? IDLE : I_WAIT;
      CLEAR:   w_next = (w_clr_done || w_timeout) ? IDLE : CLEAR;
      PRINT:   w_next = (w_prt_done || w_timeout) ? IDLE : PRINT;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready   = r_state == IDLE;
    busy        = r_state != IDLE;
    d_req_valid = r_state == D_ISSUE;
    i_req_valid = r_state == I_ISSUE;
    clr_req     = r_state == CLEAR;
    print_req   = r_state == PRINT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_op        <= READ;
      r_count     <= '0;
      r_iflag     <= 1'b0;
      r_dflag     <= 1'b0;
      r_i_hit     <= 1'b0;
      r_i_miss    <= 1'b0;
      r_d_hit     <= 1'b0;
      r_d_miss    <= 1'b0;
      r_stats_clr <= 1'b0;
      r_bad       <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_op   <= decode_op(cmd_n);
      end
      if (w_clr_done || w_timeout) begin
        r_iflag <= 1'b0;
        r_dflag <= 1'b0;
      end else if (r_state == CLEAR) begin
        r_iflag <= r_iflag || i_clr_done;
        r_dflag <= r_dflag || d_clr_done;
      end
      if (w_clr_done) r_count <= '0;
      else if (w_accept && w_legal && !(&r_count)) r_count <= r_count + 1'b1;
      r_d_hit     <= w_d_done && w_d_count && d_resp_hit;
      r_d_miss    <= w_d_done && w_d_count && !d_resp_hit;
      r_i_hit     <= w_i_done && i_resp_hit;
      r_i_miss    <= w_i_done && !i_resp_hit;
      r_stats_clr <= w_clr_done;
      r_bad       <= w_accept && !w_legal;
      r_timeout   <= w_timeout;
    end
  end
  assign d_req_op   = r_op;
  assign d_req_addr = r_addr;
  assign i_req_addr = r_addr;
  assign d_hit      = r_d_hit;
  assign d_miss     = r_d_miss;
  assign i_hit      = r_i_hit;
  assign i_miss     = r_i_miss;
  assign stats_clr  = r_stats_clr;
  assign bad_cmd    = r_bad;
  assign timeout    = r_timeout;
  assign cmd_count  = r_count;
endmodule
